// File: rtl/conv_line_buffer_k.sv
// ============================================================================
//  Module   : conv_line_buffer_k
//  Brief    : K-row sliding line buffer; emits one column of KROWS vertically
//             aligned words per accepted input once KROWS-1 rows are buffered.
//             Optional top zero padding: LINEBUF_ZERO_PAD_EN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_line_buffer_k #(
    parameter int DATA_WIDTH = 64,
    parameter int KROWS      = 3,
    parameter int MAX_LINE   = 32,
    parameter int LINE_LG2   = $clog2(MAX_LINE)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        new_filter,
    input  logic [LINE_LG2:0]           cfg_line_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [KROWS*DATA_WIDTH-1:0] out_data,
    output logic [LINE_LG2-1:0]         out_col,
    output logic                        out_last
);

    localparam int                  c_rf_w    = $clog2(KROWS);
    localparam logic [c_rf_w-1:0]   c_rf_full = c_rf_w'(KROWS - 1);
    localparam logic [LINE_LG2:0]   c_max_len = (LINE_LG2 + 1)'(MAX_LINE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t                         r_state;
    logic [LINE_LG2:0]              r_line_len;
    logic [LINE_LG2-1:0]            r_col;
    logic [c_rf_w-1:0]              r_rows_filled;
    logic [DATA_WIDTH-1:0]          r_mem [KROWS-1][MAX_LINE];

    logic                           w_accept;
    logic                           w_last_col;
    logic                           w_emit;
    logic [KROWS*DATA_WIDTH-1:0]    w_col_data;

    assign in_ready   = (r_state != ST_IDLE) && !new_filter && (!out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_last_col = ({1'b0, r_col} == (r_line_len - 1'b1));

`ifdef LINEBUF_ZERO_PAD_EN
    logic [c_rf_w-1:0] w_pad_rows;

    // Rows not yet received above the current line read as zero.
    assign w_pad_rows = c_rf_full - r_rows_filled;
    assign w_emit     = w_accept;
`else
    assign w_emit     = w_accept && (r_state == ST_STREAM);
`endif

    generate
        for (genvar k = 0; k < KROWS - 1; k++) begin : g_slice
`ifdef LINEBUF_ZERO_PAD_EN
            assign w_col_data[k*DATA_WIDTH +: DATA_WIDTH] =
                (c_rf_w'(k) < w_pad_rows) ? '0 : r_mem[k][r_col];
`else
            assign w_col_data[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[k][r_col];
`endif
        end : g_slice
    endgenerate

    assign w_col_data[(KROWS-1)*DATA_WIDTH +: DATA_WIDTH] = in_data;

    // Each line memory column shifts up one row as the new word arrives.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < KROWS - 2; k++) begin
                r_mem[k][r_col] <= r_mem[k+1][r_col];
            end
            r_mem[KROWS-2][r_col] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_line_len    <= c_max_len;
            r_col         <= '0;
            r_rows_filled <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_col       <= '0;
            out_last      <= 1'b0;
        end else if (new_filter) begin
            r_state       <= ST_FILL;
            r_col         <= '0;
            r_rows_filled <= '0;
            out_valid     <= 1'b0;
            r_line_len    <= ((cfg_line_len == '0) || (cfg_line_len > c_max_len))
                             ? c_max_len : cfg_line_len;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_last_col) begin
                    r_col <= '0;
                    if (r_rows_filled != c_rf_full) begin
                        r_rows_filled <= r_rows_filled + 1'b1;
                    end
                    if (r_rows_filled == (c_rf_full - 1'b1)) begin
                        r_state <= ST_STREAM;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (w_emit) begin
                    out_valid <= 1'b1;
                    out_data  <= w_col_data;
                    out_col   <= r_col;
                    out_last  <= w_last_col;
                end
            end
        end
    end

endmodule : conv_line_buffer_k

`default_nettype wire
